// File: rtl/serial_sequence_detector.sv
// Serial pattern detector with frame-lock FSM; receiver-side counterpart of the
// serial sequence generator. Flags each N-bit pattern hit and tracks period lock.
module serial_sequence_detector #(
  parameter int                     PATTERN_LEN = 8,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 8'b1011_0100,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     LOCK_COUNT  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_valid,
  input  logic       din,
  output logic       detect,
  output logic [7:0] match_cnt,
  output logic       locked,
  output logic       bit_err
);

  localparam int CW = $clog2(PATTERN_LEN + 1);
  localparam int PW = $clog2(PATTERN_LEN);
  localparam logic [CW-1:0] FILL_FULL   = CW'(PATTERN_LEN);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(PATTERN_LEN - 1);
  localparam logic [3:0]    LOCK_TARGET = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t                 state, state_nxt;
  logic [PATTERN_LEN-1:0] sreg, sreg_nxt;
  logic [CW-1:0]          fill, fill_inc, fill_nxt;
  logic [PW-1:0]          phase, phase_adv, phase_nxt;
  logic [3:0]             period, period_nxt;
  logic                   hit, err, exp_bit;

  // Everything below only moves on a valid bit; idle cycles leave state untouched.
  always_comb begin
    sreg_nxt   = sreg;
    fill_inc   = fill;
    fill_nxt   = fill;
    phase_nxt  = phase;
    period_nxt = period;
    state_nxt  = state;
    hit        = 1'b0;
    err        = 1'b0;
    exp_bit    = PATTERN[PHASE_LAST - phase];
    phase_adv  = (phase == PHASE_LAST) ? '0 : phase + 1'b1;

    if (din_valid) begin
      sreg_nxt = {sreg[PATTERN_LEN-2:0], din};
      fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
      hit      = (fill_inc == FILL_FULL) && (sreg_nxt == PATTERN);
      fill_nxt = (hit && !OVERLAP) ? '0 : fill_inc;

      // A fall-back to SEARCH ignores a coincident hit; re-arming needs a later one.
      case (state)
        SEARCH: begin
          if (hit) begin
            state_nxt  = (LOCK_COUNT > 1) ? VERIFY : LOCKED;
            phase_nxt  = '0;
            period_nxt = 4'd1;
          end
        end
        VERIFY: begin
          if (din != exp_bit) begin
            state_nxt = SEARCH;
          end else begin
            phase_nxt = phase_adv;
            if (phase == PHASE_LAST) period_nxt = period + 4'd1;
            if (period_nxt == LOCK_TARGET) state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (din != exp_bit) begin
            err       = 1'b1;
            state_nxt = SEARCH;
          end else begin
            phase_nxt = phase_adv;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      sreg      <= '0;
      fill      <= '0;
      phase     <= '0;
      period    <= '0;
      detect    <= 1'b0;
      match_cnt <= 8'd0;
      locked    <= 1'b0;
      bit_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      fill    <= fill_nxt;
      phase   <= phase_nxt;
      period  <= period_nxt;
      detect  <= hit;
      bit_err <= err;
      locked  <= (state_nxt == LOCKED);
      if (hit && match_cnt != 8'hFF) match_cnt <= match_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_serial_sequence_detector.sv
// Directed bench for serial_sequence_detector: periodic lock, bit error,
// overlap modes, gapped valid, mid-stream reset and counter saturation.
module tb_serial_sequence_detector;

  logic       clk = 1'b0;
  logic       rst, din_valid, din;
  logic       det_a, lck_a, err_a, det_b, lck_b, err_b, det_c, lck_c, err_c;
  logic [7:0] cnt_a, cnt_b, cnt_c;

  int tests    = 0;
  int failures = 0;

  logic [7:0] pat     = 8'b1011_0100;
  logic [7:0] pat_alt = 8'b1010_1010;
  logic [10:0] post_stream = 11'b100_1011_0100;

  always #5 clk = ~clk;

  serial_sequence_detector dut_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .detect(det_a), .match_cnt(cnt_a), .locked(lck_a), .bit_err(err_a));

  serial_sequence_detector #(.PATTERN(8'b1010_1010), .OVERLAP(1'b1)) dut_b (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .detect(det_b), .match_cnt(cnt_b), .locked(lck_b), .bit_err(err_b));

  serial_sequence_detector #(.PATTERN(8'b1010_1010), .OVERLAP(1'b0)) dut_c (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .detect(det_c), .match_cnt(cnt_c), .locked(lck_c), .bit_err(err_c));

  // Inputs change on the falling edge; registered outputs are read one falling edge later.
  task automatic applyStimulus(input logic v, input logic d);
    din_valid = v;
    din       = d;
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic b, exp_det, exp_lck;
    int   g;

    rst = 1'b1; din_valid = 1'b0; din = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_detect", {7'd0, det_a}, 8'd0);
    checkOutput("rst_cnt",    cnt_a,         8'd0);
    checkOutput("rst_locked", {7'd0, lck_a}, 8'd0);
    checkOutput("rst_err",    {7'd0, err_a}, 8'd0);
    checkOutput("rst_cnt_b",  cnt_b,         8'd0);
    checkOutput("rst_cnt_c",  cnt_c,         8'd0);

    // Seven periods; bit 35 (3rd bit of period 5) is flipped.
    for (int k = 1; k <= 56; k++) begin
      b = pat[7 - ((k - 1) % 8)] ^ (k == 35);
      applyStimulus(1'b1, b);
      exp_det = (k % 8 == 0) && (k != 40);
      exp_lck = (k >= 16 && k < 35) || (k >= 56);
      checkOutput($sformatf("per_detect_%0d", k), {7'd0, det_a}, {7'd0, exp_det});
      checkOutput($sformatf("per_locked_%0d", k), {7'd0, lck_a}, {7'd0, exp_lck});
      checkOutput($sformatf("per_err_%0d", k),    {7'd0, err_a}, {7'd0, (k == 35)});
      if (k == 32) checkOutput("per_cnt_32", cnt_a, 8'd4);
    end
    checkOutput("per_cnt_56", cnt_a, 8'd6);

    applyReset();
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, pat_alt[7 - ((k - 1) % 8)]);
      checkOutput($sformatf("ovl1_detect_%0d", k), {7'd0, det_b}, {7'd0, (k == 8 || k == 10)});
      checkOutput($sformatf("ovl0_detect_%0d", k), {7'd0, det_c}, {7'd0, (k == 8)});
    end
    checkOutput("ovl1_cnt", cnt_b, 8'd2);
    checkOutput("ovl0_cnt", cnt_c, 8'd1);

    // Gapped valid: each valid bit is followed by an idle cycle carrying the wrong bit.
    applyReset();
    for (int k = 1; k <= 32; k++) begin
      b = pat[7 - ((k - 1) % 8)];
      exp_lck = (k >= 16);
      applyStimulus(1'b1, b);
      checkOutput($sformatf("gap_detect_%0d", k), {7'd0, det_a}, {7'd0, (k % 8 == 0)});
      checkOutput($sformatf("gap_locked_%0d", k), {7'd0, lck_a}, {7'd0, exp_lck});
      applyStimulus(1'b0, ~b);
      checkOutput($sformatf("gap_idle_detect_%0d", k), {7'd0, det_a}, 8'd0);
      checkOutput($sformatf("gap_idle_err_%0d", k),    {7'd0, err_a}, 8'd0);
      checkOutput($sformatf("gap_idle_locked_%0d", k), {7'd0, lck_a}, {7'd0, exp_lck});
      checkOutput($sformatf("gap_idle_cnt_%0d", k),    cnt_a, 8'(k / 8));
    end
    checkOutput("gap_cnt", cnt_a, 8'd4);

    // Mid-period reset while locked; the rest of the interrupted period must not complete a hit.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, pat[7 - k]);
    checkOutput("mid_locked_before", {7'd0, lck_a}, 8'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    rst = 1'b0;
    checkOutput("mid_rst_detect", {7'd0, det_a}, 8'd0);
    checkOutput("mid_rst_cnt",    cnt_a,         8'd0);
    checkOutput("mid_rst_locked", {7'd0, lck_a}, 8'd0);
    checkOutput("mid_rst_err",    {7'd0, err_a}, 8'd0);
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(1'b1, post_stream[11 - k]);
      checkOutput($sformatf("mid_detect_%0d", k), {7'd0, det_a}, {7'd0, (k == 11)});
    end
    checkOutput("mid_cnt",    cnt_a,         8'd1);
    checkOutput("mid_locked", {7'd0, lck_a}, 8'd0);

    applyReset();
    for (int p = 1; p <= 300; p++) begin
      for (int i = 0; i < 8; i++) begin
        g = (p - 1) * 8 + i + 1;
        applyStimulus(1'b1, pat[7 - i]);
        checkOutput($sformatf("sat_err_%0d", g),    {7'd0, err_a}, 8'd0);
        checkOutput($sformatf("sat_locked_%0d", g), {7'd0, lck_a}, {7'd0, (g >= 16)});
      end
      checkOutput($sformatf("sat_detect_%0d", p), {7'd0, det_a}, 8'd1);
      if (p == 254) checkOutput("sat_cnt_254", cnt_a, 8'd254);
      if (p == 255) checkOutput("sat_cnt_255", cnt_a, 8'd255);
    end
    checkOutput("sat_cnt_300", cnt_a, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/serial_sequence_detector.md
Name: serial_sequence_detector

Overview:
Receiver-side counterpart to the team's serial sequence generator. Samples a one-bit serial stream and flags every occurrence of a programmable N-bit pattern. Runs a frame-lock FSM that declares lock once the stream repeats the pattern period after period, and reports bit errors while locked. Sits directly on the generator's out line, or on any serial source sharing its clock.

Parameters:
PATTERN_LEN, 8, pattern length N in bits (2..16)
PATTERN, 8'b1011_0100, expected sequence, MSB is the first bit received
OVERLAP, 1, 1 = overlapping detection; 0 = the shift history restarts after each hit
LOCK_COUNT, 2, consecutive correct periods (including the initial hit) required to enter LOCKED (1..15)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
din_valid  input  1  qualifies din; all state advances only on cycles with din_valid=1
din  input  1  serial data bit
detect  output  1  one-cycle pulse: the last N valid bits equal PATTERN
match_cnt  output  8  number of detect pulses since reset, saturates at 255
locked  output  1  high while the FSM is in LOCKED
bit_err  output  1  one-cycle pulse: mismatching bit received while LOCKED

Behaviour:
- Reset: rst=1 at a rising edge clears all registers at that edge.
  - detect=0, match_cnt=0, locked=0, bit_err=0.
  - Shift register=0, fill count=0, FSM=SEARCH, phase=0, period count=0.
- Reset wins over every other event. Mid-stream reset discards partial history, so a pattern straddling the reset is not detected.
- All outputs are registered. Latency is 1 clock: a pulse appears in the cycle after the edge that samples the completing bit.
- din_valid=0 cycles:
  - No state changes.
  - detect and bit_err are 0.
  - match_cnt and locked hold.
- Shift register:
  - On each valid bit: sreg <= {sreg[N-2:0], din}.
  - fill count increments, saturating at N.
- Detection: detect=1 when fill count (after the increment) reaches N and the new sreg equals PATTERN.
  - OVERLAP=0: a hit resets fill count to 0, so the next hit needs N fresh bits.
  - OVERLAP=1: fill count stays at N.
- match_cnt increments on each detect and holds at 8'hFF.
- Lock FSM: phase counts valid bits modulo N. Expected bit = PATTERN[N-1-phase].
  - SEARCH:
    - On detect: go to VERIFY if LOCK_COUNT>1, otherwise go directly to LOCKED.
    - Set phase=0 and period count=1.
  - VERIFY, each valid bit:
    - din != expected bit: go to SEARCH, no bit_err.
    - Otherwise advance phase. On wrap N-1 -> 0, increment period count.
    - When period count reaches LOCK_COUNT, go to LOCKED.
  - LOCKED, each valid bit:
    - din != expected bit: pulse bit_err, go to SEARCH, drop locked in the same cycle as bit_err.
    - Otherwise advance phase.
  - The erroring bit is still shifted into sreg. Detection keeps running in every state.
- Simultaneous events: a detect on the same bit that causes VERIFY or LOCKED to fall back to SEARCH does not re-arm the FSM. Re-arming needs a later detect while in SEARCH.
- locked updates in the cycle after the deciding bit, with the same timing as detect.

Test Plan:
- Periodic stream: reset, then feed 10110100 repeated 4 times with din_valid=1 every cycle.
  - detect pulses once per period: first after bit 8, then after bits 16, 24, 32.
  - match_cnt=4.
  - locked rises 1 cycle after bit 16 (LOCK_COUNT=2) and stays high.
- Bit error while locked: after lock, flip the 3rd bit of the 5th period.
  - bit_err pulses exactly once and locked falls in that same cycle.
  - The next 2 clean periods re-acquire lock.
- Overlap check: pattern 8'b1010_1010, stream 1010101010.
  - OVERLAP=1 gives detect after bits 8 and 10 (match_cnt=2).
  - OVERLAP=0 gives a single detect after bit 8 (match_cnt=1).
- Gapped valid: repeat the first scenario with din_valid toggling 1,0,1,0.
  - Same detect, lock and count results, with pulses aligned to valid bits only.
  - detect is 0 on every din_valid=0 cycle.
- Reset mid-operation: assert rst for 1 cycle while locked, in the middle of a period.
  - Next cycle all outputs are 0.
  - The first detect comes only after a complete fresh 8-bit pattern.
- Saturation: 300 back-to-back periods give match_cnt=255 that holds; locked stays 1 and bit_err never fires.
